// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer/count/flag sequencer for an external dual-port RAM FIFO
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 16,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clock,
  input  logic                  fifo_rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  output logic                  write_allow,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  read_allow,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  read_valid,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  // Wrap point is explicit so non-power-of-two depths never address past the last entry.
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT  = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_CNT  = (ADDR_WIDTH + 1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0]   AEMPTY_CNT = (ADDR_WIDTH + 1)'(AEMPTY_LVL);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  push_rejected;
  logic                  pop_on_empty;

  // Accept decisions: a pop frees a slot, so a push into a full FIFO is legal alongside it.
  // The reset term keeps the RAM strobes quiet while the FIFO is held in reset.
  always_comb begin
    pop_ok        = fifo_rst_n & pop & ~clear & ~empty;
    push_ok       = fifo_rst_n & push & ~clear & (~full | pop_ok);
    push_rejected = push & ~clear & ~push_ok;
    pop_on_empty  = pop & ~clear & empty;
  end

  assign write_allow = push_ok;
  assign read_allow  = pop_ok;
  assign write_addr  = wr_ptr;
  assign read_addr   = rd_ptr;
  assign fifo_count  = count;

  // Level flags come straight from the registered count.
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  // Write pointer: advance on each accepted push, wrapping at the last usable entry.
  always_ff @(posedge clock or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      wr_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
    end else if (push_ok) begin
      wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Read pointer: advance on each accepted pop, wrapping at the last usable entry.
  always_ff @(posedge clock or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      rd_ptr <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
    end else if (pop_ok) begin
      rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Occupancy: the accept logic already bounds it to 0..RAM_DEPTH.
  always_ff @(posedge clock or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Read data from the RAM is registered, so it is valid one cycle after the accepted pop.
  always_ff @(posedge clock or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      read_valid <= 1'b0;
    end else begin
      read_valid <= pop_ok;
    end
  end

  // Sticky overflow: set by any rejected push outside a flush.
  always_ff @(posedge clock or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (push_rejected) begin
      overflow <= 1'b1;
    end
  end

  // Sticky underflow: set by any pop request while empty outside a flush.
  always_ff @(posedge clock or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      underflow <= 1'b0;
    end else if (clear) begin
      underflow <= 1'b0;
    end else if (pop_on_empty) begin
      underflow <= 1'b1;
    end
  end

endmodule
